cirno_sequencer: RTL and testbench
==================================

Name: cirno_sequencer

Overview:
- Parametrised multi-cycle control sequencer for the cirno CPU core.
- Steps each instruction through fetch (IF), decode (DC), operand fetch (OF), ALU, read mem (RM), write mem (WM) and result store (RS). The stage path depends on the instruction class.
- Drives one-hot stage enables to the fetch unit, decoder, register file, ALU and memory, plus the PC load.
- Additions: memory request/acknowledge handshake with a timeout watchdog, explicit halt/fault states, a start control and a retired-instruction counter.

Parameters:
- TYPE_W, 3, width of inst_type; classes 0..6 are defined, any other code is illegal.
- MEM_TIMEOUT, 16, maximum cycles in a memory state without mem_ack before a fault; 0 disables the watchdog.
- COUNT_W, 16, width of inst_count.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- init_n  in  1  synchronous active-low reset.
- start  in  1  leaves IDLE to begin fetching; ignored in every other state.
- inst_type  in  TYPE_W  instruction class from the decoder; valid during DC.
- branch_cond  in  1  branch taken (unconditional jumps drive 1).
- mem_ack  in  1  memory/fetch completion for the current request.
- if_en, dc_en, of_en, alu_en, rm_en, wm_en, rs_en  out  1 each  stage enables; at most one high per cycle.
- mem_req  out  1  high in IF, RM and WM.
- pc_load  out  1  load branch target into the fetch unit this cycle.
- done  out  1  high while in HALT.
- fault  out  1  sticky error flag.
- fault_code  out  2  01 = illegal class, 10 = memory timeout, 00 = none.
- inst_count  out  COUNT_W  retired instructions, saturating.

Behaviour:
- States: IDLE, IF, DC, OF, ALU, RM, WM, RS, HALT.
- Outputs are Moore-decoded from the state register; pc_load is the exception (see below).
- Reset (init_n low at a rising edge, in any state including mid-memory-wait):
  - next state is IDLE;
  - fault = 0, fault_code = 0, inst_count = 0, wait counter = 0, latched class = 0;
  - all enables, mem_req, pc_load and done are low.
- IDLE -> IF when start = 1.
- IF -> DC on mem_ack. inst_type is latched into an internal class register on the DC exit edge.
- Class paths (each path returns to IF after its last stage):
  - 0 ALU op: IF DC OF ALU RS
  - 1 immediate jump or nil: IF DC
  - 2 register jump: IF DC OF
  - 3 move/immediate load: IF DC RS
  - 4 store: IF DC OF WM
  - 5 load: IF DC OF RM RS
  - 6 halt: IF DC HALT
- Illegal class (7, or any code >= 7 when TYPE_W > 3): DC -> HALT with fault = 1, fault_code = 01.
- Every non-memory state (DC, OF, ALU, RS) lasts exactly 1 cycle. Class 0 therefore takes IF wait + 4 cycles.
- Memory states (IF, RM, WM):
  - exit on the first edge where mem_ack = 1; mem_ack high on the entry cycle gives a 1-cycle stay;
  - the wait counter clears on state entry and increments each cycle without mem_ack;
  - when it reaches MEM_TIMEOUT with mem_ack still low: -> HALT, fault = 1, fault_code = 10;
  - mem_ack outside memory states is ignored.
- pc_load (combinational, 1-cycle pulse, no stall):
  - high in DC when the live inst_type = 1 and branch_cond = 1;
  - high in OF when the latched class = 2 and branch_cond = 1.
- Retirement:
  - inst_count increments by 1 on each edge that moves from a final stage back to IF, and on DC -> HALT for class 6;
  - faulting instructions do not count;
  - saturates at 2^COUNT_W - 1 (no wrap).
- HALT is terminal until reset: done = 1, all enables low, start ignored.
- fault and fault_code hold until reset. First fault wins; only one fault can occur per run because HALT is terminal.

Test Plan:
- Reset, start pulse, mem_ack always 1, class 0 stream:
  - enables run if, dc, of, alu, rs (1 cycle each, repeating);
  - inst_count = 3 after three instructions.
- Class 5 with mem_ack delayed 3 cycles in RM -> rm_en high 4 cycles, then rs_en 1 cycle; no fault.
- Branches:
  - class 1, branch_cond = 1 -> pc_load high exactly in the DC cycle, next state IF;
  - class 2, branch_cond = 0 -> pc_load never asserts.
- MEM_TIMEOUT = 4, mem_ack held low in IF -> HALT after 4 waiting cycles; done = 1, fault = 1, fault_code = 10, inst_count unchanged.
- inst_type = 7 at DC -> HALT, fault_code = 01; later start pulses are ignored.
- init_n low for 1 cycle during WM -> IDLE with all outputs 0, inst_count = 0; start resumes in IF.

Source files
------------

// File: rtl/cirno_sequencer.sv
// cirno_sequencer: multi-cycle stage sequencer with memory watchdog, halt/fault states and retire counter
module cirno_sequencer #(
   parameter int TYPE_W      = 3,
   parameter int MEM_TIMEOUT = 16,
   parameter int COUNT_W     = 16
) (
   input  logic               clk,
   input  logic               init_n,
   input  logic               start,
   input  logic [TYPE_W-1:0]  inst_type,
   input  logic               branch_cond,
   input  logic               mem_ack,
   output logic               if_en,
   output logic               dc_en,
   output logic               of_en,
   output logic               alu_en,
   output logic               rm_en,
   output logic               wm_en,
   output logic               rs_en,
   output logic               mem_req,
   output logic               pc_load,
   output logic               done,
   output logic               fault,
   output logic [1:0]         fault_code,
   output logic [COUNT_W-1:0] inst_count
);
   typedef enum logic [3:0] {IDLE, S_IF, S_DC, S_OF, S_ALU, S_RM, S_WM, S_RS, HALT} state_t;
   localparam int WAIT_W = MEM_TIMEOUT > 0 ? $clog2(MEM_TIMEOUT + 1) : 1;
   state_t            state, nxt;
   logic [WAIT_W-1:0] wait_cnt;
   logic [TYPE_W-1:0] cls;
   logic              is_mem, timeout, retire, illegal;
   always_comb begin
      is_mem  = state == S_IF || state == S_RM || state == S_WM;
      timeout = MEM_TIMEOUT != 0 && is_mem && !mem_ack && wait_cnt == WAIT_W'(MEM_TIMEOUT - 1);
      illegal = state == S_DC && inst_type >= TYPE_W'(7);
      nxt     = state;
      case (state)
         IDLE:    nxt = start ? S_IF : IDLE;
         S_IF:    nxt = mem_ack ? S_DC : S_IF;
         S_DC:    nxt = inst_type == TYPE_W'(1) ? S_IF : inst_type == TYPE_W'(3) ? S_RS :
                        inst_type >= TYPE_W'(6) ? HALT : S_OF;
         S_OF:    nxt = cls == TYPE_W'(0) ? S_ALU : cls == TYPE_W'(4) ? S_WM :
                        cls == TYPE_W'(5) ? S_RM : S_IF;
         S_ALU:   nxt = S_RS;
         S_RM:    nxt = mem_ack ? S_RS : S_RM;
         S_WM:    nxt = mem_ack ? S_IF : S_WM;
         S_RS:    nxt = S_IF;
         default: nxt = HALT;
      endcase
      if (timeout) nxt = HALT;
      // a final stage is any state other than IDLE/IF that hands back to IF
      retire = (nxt == S_IF && state != S_IF && state != IDLE) ||
               (state == S_DC && inst_type == TYPE_W'(6));
   end
   always_ff @(posedge clk) begin
      if (!init_n) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         cls        <= '0;
         fault      <= 1'b0;
         fault_code <= 2'b00;
         inst_count <= '0;
      end else begin
         state    <= nxt;
         wait_cnt <= (nxt == state && is_mem) ? wait_cnt + 1'b1 : '0;
         if (state == S_DC) cls <= inst_type;
         if (timeout) begin
            fault      <= 1'b1;
            fault_code <= 2'b10;
         end else if (illegal) begin
            fault      <= 1'b1;
            fault_code <= 2'b01;
         end
         if (retire && inst_count != '1) inst_count <= inst_count + 1'b1;
      end
   end
   assign if_en   = state == S_IF;
   assign dc_en   = state == S_DC;
   assign of_en   = state == S_OF;
   assign alu_en  = state == S_ALU;
   assign rm_en   = state == S_RM;
   assign wm_en   = state == S_WM;
   assign rs_en   = state == S_RS;
   assign mem_req = if_en || rm_en || wm_en;
   assign done    = state == HALT;
   assign pc_load = branch_cond && ((dc_en && inst_type == TYPE_W'(1)) || (of_en && cls == TYPE_W'(2)));
endmodule

// File: tb/tb_cirno_sequencer.sv
// tb_cirno_sequencer: directed per-cycle vectors queued as expectations, checked by a negedge monitor
module tb_cirno_sequencer;
   logic       clk = 1'b0;
   logic       init_n = 1'b0, start = 1'b0, branch_cond = 1'b0, mem_ack = 1'b0;
   logic [2:0] inst_type = '0;
   logic       if_en, dc_en, of_en, alu_en, rm_en, wm_en, rs_en, mem_req, pc_load, done, fault;
   logic [1:0] fault_code, inst_count;
   int         checks = 0, errors = 0;

   typedef struct packed {
      logic [6:0] en;
      logic       mr, pl, dn, f;
      logic [1:0] fc, cnt;
   } exp_t;
   exp_t q[$];

   localparam logic [6:0] NO = 7'b0000000, IFS = 7'b1000000, DCS = 7'b0100000, OFS = 7'b0010000,
                          ALS = 7'b0001000, RMS = 7'b0000100, WMS = 7'b0000010, RSS = 7'b0000001;

   cirno_sequencer #(.TYPE_W(3), .MEM_TIMEOUT(4), .COUNT_W(2)) dut (
      .clk(clk), .init_n(init_n), .start(start), .inst_type(inst_type), .branch_cond(branch_cond),
      .mem_ack(mem_ack), .if_en(if_en), .dc_en(dc_en), .of_en(of_en), .alu_en(alu_en), .rm_en(rm_en),
      .wm_en(wm_en), .rs_en(rs_en), .mem_req(mem_req), .pc_load(pc_load), .done(done), .fault(fault),
      .fault_code(fault_code), .inst_count(inst_count)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e, a;
         e = q.pop_front();
         a = '{en: {if_en, dc_en, of_en, alu_en, rm_en, wm_en, rs_en}, mr: mem_req, pl: pc_load,
               dn: done, f: fault, fc: fault_code, cnt: inst_count};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL cycle_check #%0d at %0t: got en=%b req=%b pl=%b done=%b f=%b fc=%b cnt=%0d, want en=%b req=%b pl=%b done=%b f=%b fc=%b cnt=%0d",
                     checks, $time, a.en, a.mr, a.pl, a.dn, a.f, a.fc, a.cnt,
                     e.en, e.mr, e.pl, e.dn, e.f, e.fc, e.cnt);
         end
      end
   end

   task automatic cyc(input logic [6:0] en, input logic pl, dn, f, input logic [1:0] fc, cnt,
                      input logic rn, st, input logic [2:0] it, input logic br, ak);
      init_n = rn; start = st; inst_type = it; branch_cond = br; mem_ack = ak;
      q.push_back('{en: en, mr: en[6] | en[2] | en[1], pl: pl, dn: dn, f: f, fc: fc, cnt: cnt});
      @(posedge clk); #1;
   endtask

   task automatic run(input logic [6:0] en, input logic [1:0] cnt, input logic [2:0] it,
                      input logic br, ak, pl);
      cyc(en, pl, 1'b0, 1'b0, 2'b00, cnt, 1'b1, 1'b0, it, br, ak);
   endtask

   task automatic do_reset;
      init_n = 1'b0;
      @(posedge clk); #1;
      cyc(NO, 0, 0, 0, 2'b00, 2'd0, 1'b1, 1'b0, 3'd0, 0, 0);
   endtask

   initial begin
      do_reset();
      cyc(NO, 0, 0, 0, 2'b00, 2'd0, 1'b1, 1'b1, 3'd0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         run(IFS, 2'(i), 3'd0, 0, 1, 0);
         run(DCS, 2'(i), 3'd0, 0, 1, 0);
         run(OFS, 2'(i), 3'd0, 0, 1, 0);
         run(ALS, 2'(i), 3'd0, 0, 1, 0);
         run(RSS, 2'(i), 3'd0, 0, 1, 0);
      end
      // class 5 with a 3-cycle RM wait; counter already saturated at 3
      run(IFS, 2'd3, 3'd0, 0, 1, 0);
      run(DCS, 2'd3, 3'd5, 0, 1, 0);
      run(OFS, 2'd3, 3'd0, 0, 1, 0);
      for (int i = 0; i < 3; i++) run(RMS, 2'd3, 3'd0, 0, 0, 0);
      run(RMS, 2'd3, 3'd0, 0, 1, 0);
      run(RSS, 2'd3, 3'd0, 0, 0, 0);
      run(IFS, 2'd3, 3'd0, 0, 1, 0);
      run(DCS, 2'd3, 3'd1, 1, 1, 1);
      run(IFS, 2'd3, 3'd0, 0, 1, 0);
      run(DCS, 2'd3, 3'd2, 0, 1, 0);
      run(OFS, 2'd3, 3'd0, 0, 1, 0);
      run(IFS, 2'd3, 3'd0, 0, 1, 0);
      run(DCS, 2'd3, 3'd2, 1, 1, 0);
      run(OFS, 2'd3, 3'd0, 1, 1, 1);
      run(IFS, 2'd3, 3'd0, 0, 1, 0);
      run(DCS, 2'd3, 3'd3, 0, 1, 0);
      run(RSS, 2'd3, 3'd0, 0, 1, 0);
      // store, reset asserted mid-WM wait
      run(IFS, 2'd3, 3'd0, 0, 1, 0);
      run(DCS, 2'd3, 3'd4, 0, 1, 0);
      run(OFS, 2'd3, 3'd0, 0, 0, 0);
      run(WMS, 2'd3, 3'd0, 0, 0, 0);
      cyc(WMS, 0, 0, 0, 2'b00, 2'd3, 1'b0, 1'b0, 3'd0, 0, 0);
      cyc(NO, 0, 0, 0, 2'b00, 2'd0, 1'b1, 1'b0, 3'd0, 0, 1);
      cyc(NO, 0, 0, 0, 2'b00, 2'd0, 1'b1, 1'b1, 3'd0, 0, 0);
      run(IFS, 2'd0, 3'd0, 0, 1, 0);
      run(DCS, 2'd0, 3'd3, 0, 1, 0);
      run(RSS, 2'd0, 3'd0, 0, 1, 0);
      // fetch timeout after 4 waiting cycles
      for (int i = 0; i < 4; i++) run(IFS, 2'd1, 3'd0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc(NO, 0, 1, 1, 2'b10, 2'd1, 1'b1, 1'b1, 3'd0, 0, 1);
      // halt instruction retires
      do_reset();
      cyc(NO, 0, 0, 0, 2'b00, 2'd0, 1'b1, 1'b1, 3'd0, 0, 0);
      run(IFS, 2'd0, 3'd0, 0, 1, 0);
      run(DCS, 2'd0, 3'd6, 0, 1, 0);
      cyc(NO, 0, 1, 0, 2'b00, 2'd1, 1'b1, 1'b1, 3'd0, 0, 0);
      // illegal class faults, later starts ignored
      do_reset();
      cyc(NO, 0, 0, 0, 2'b00, 2'd0, 1'b1, 1'b1, 3'd0, 0, 0);
      run(IFS, 2'd0, 3'd0, 0, 1, 0);
      run(DCS, 2'd0, 3'd7, 0, 1, 0);
      for (int i = 0; i < 3; i++) cyc(NO, 0, 1, 1, 2'b01, 2'd0, 1'b1, 1'b1, 3'd0, 0, 1);
      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain: %0d entries left, want 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
